// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the QoS priority arbiter: level compare/max,
// top-level constant and round-robin wrap increment.
package arbiter_pkg;

  localparam int unsigned PRIORITY_WIDTH_DEF = 2;
  localparam int unsigned LEVEL_W_MAX        = 8;

  typedef logic [LEVEL_W_MAX-1:0] level_t;

  function automatic level_t level_max(input level_t a, input level_t b);
    return (a > b) ? a : b;
  endfunction

  function automatic level_t level_top(input int unsigned pw);
    return level_t'((1 << pw) - 1);
  endfunction

  function automatic int unsigned rr_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_queue.sv
// Per-channel request FIFO. A pushed entry becomes visible at the head one
// cycle after it is written; the not-full flag is registered and 0 in reset.
module fifo_queue #(
  parameter int unsigned DATA_WIDTH = 66,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_push_data,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_head_data,
  output logic                  o_head_valid,
  output logic                  o_not_full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      r_vis;
  logic                  r_push_d;
  logic                  r_not_full;
  logic [CNT_W-1:0]      w_count_nxt;
  logic [CNT_W-1:0]      w_vis_nxt;
  logic                  w_push;
  logic                  w_pop;

  assign w_pop       = i_pop & (r_vis != '0);
  assign w_push      = i_push & ((r_count != FULL_CNT) | w_pop);
  assign w_count_nxt = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
  // r_vis trails r_count by the entry written on the previous edge
  assign w_vis_nxt   = r_vis + CNT_W'(r_push_d) - CNT_W'(w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_vis      <= '0;
      r_push_d   <= 1'b0;
      r_not_full <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count    <= w_count_nxt;
      r_vis      <= w_vis_nxt;
      r_push_d   <= w_push;
      r_not_full <= (w_count_nxt != FULL_CNT);
    end
  end

  assign o_head_data  = r_mem[r_rd_ptr];
  assign o_head_valid = (r_vis != '0);
  assign o_not_full   = r_not_full;

endmodule

// File: rtl/qos_select.sv
// Combinational winner select: highest effective level, aged heads first
// among ties, then round-robin starting after the last grant.
module qos_select
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQUEST      = 4,
  parameter int unsigned PRIORITY_WIDTH   = 2,
  parameter int unsigned NUM_REQUEST_LOG2 = 2
) (
  input  logic [NUM_REQUEST-1:0]                i_valid,
  input  logic [NUM_REQUEST*PRIORITY_WIDTH-1:0] i_level,
  input  logic [NUM_REQUEST-1:0]                i_aged,
  input  logic [NUM_REQUEST_LOG2-1:0]           i_last_grant,
  output logic [NUM_REQUEST_LOG2-1:0]           o_winner,
  output logic                                  o_any_valid
);

  level_t                      w_max;
  logic [NUM_REQUEST-1:0]      w_top;
  logic [NUM_REQUEST-1:0]      w_cand;
  logic [NUM_REQUEST_LOG2-1:0] w_idx;
  logic                        w_found;

  always_comb begin
    w_max = '0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      if (i_valid[i])
        w_max = level_max(w_max, level_t'(i_level[i*PRIORITY_WIDTH +: PRIORITY_WIDTH]));
    end
  end

  always_comb begin
    w_top = '0;
    for (int i = 0; i < NUM_REQUEST; i++) begin
      w_top[i] = i_valid[i] &&
                 (level_t'(i_level[i*PRIORITY_WIDTH +: PRIORITY_WIDTH]) == w_max);
    end
    w_cand = (|(w_top & i_aged)) ? (w_top & i_aged) : w_top;
  end

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = i_last_grant;
    for (int k = 0; k < NUM_REQUEST; k++) begin
      w_idx = NUM_REQUEST_LOG2'(rr_inc(32'(w_idx), NUM_REQUEST));
      if (!w_found && w_cand[w_idx]) begin
        o_winner = w_idx;
        w_found  = 1'b1;
      end
    end
  end

  assign o_any_valid = |i_valid;

endmodule

// File: rtl/qos_priority_arbiter.sv
// N-channel QoS arbiter: per-channel FIFOs, multi-level priority with
// starvation aging, round-robin among ties, registered valid/ack output.
module qos_priority_arbiter
  import arbiter_pkg::*;
#(
  parameter int unsigned SINGLE_REQUEST_WIDTH_IN_BITS = 64,
  parameter int unsigned NUM_REQUEST                  = 4,
  parameter int unsigned INPUT_QUEUE_SIZE             = 4,
  parameter int unsigned PRIORITY_WIDTH               = PRIORITY_WIDTH_DEF,
  parameter int unsigned AGING_THRESHOLD              = 16,
  parameter int unsigned NUM_REQUEST_LOG2             = $clog2(NUM_REQUEST)
) (
  input  logic                                                  clk_in,
  input  logic                                                  reset_n_in,
  input  logic [SINGLE_REQUEST_WIDTH_IN_BITS*NUM_REQUEST-1:0]   request_flatted_in,
  input  logic [PRIORITY_WIDTH*NUM_REQUEST-1:0]                 request_priority_flatted_in,
  input  logic [NUM_REQUEST-1:0]                                request_valid_flatted_in,
  output logic [NUM_REQUEST-1:0]                                issue_ack_out,
  output logic [SINGLE_REQUEST_WIDTH_IN_BITS-1:0]               request_out,
  output logic [PRIORITY_WIDTH-1:0]                             request_priority_out,
  output logic [NUM_REQUEST_LOG2-1:0]                           request_channel_out,
  output logic                                                  request_aged_out,
  output logic                                                  request_valid_out,
  input  logic                                                  issue_ack_in
);

  localparam int unsigned W       = SINGLE_REQUEST_WIDTH_IN_BITS;
  localparam int unsigned N       = NUM_REQUEST;
  localparam int unsigned PW      = PRIORITY_WIDTH;
  localparam int unsigned LW      = NUM_REQUEST_LOG2;
  localparam int unsigned ENTRY_W = W + PW;
  localparam int unsigned AGE_W   = (AGING_THRESHOLD == 0) ? 1 : $clog2(AGING_THRESHOLD + 1);
  localparam logic [PW-1:0]    TOP_LVL = PW'(level_top(PW));
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGING_THRESHOLD);

  logic [ENTRY_W-1:0] w_head     [N];
  logic [PW-1:0]      w_head_lvl [N];
  logic [N-1:0]       w_head_valid;
  logic [N-1:0]       w_ack;
  logic [N-1:0]       w_aged;
  logic [N*PW-1:0]    w_eff_lvl;
  logic [N-1:0]       w_pop;
  logic [LW-1:0]      w_winner;
  logic               w_any;
  logic               w_load;

  logic [AGE_W-1:0]   r_age [N];
  logic [LW-1:0]      r_last_grant;
  logic               r_valid;
  logic [W-1:0]       r_data;
  logic [PW-1:0]      r_prio;
  logic [LW-1:0]      r_chan;
  logic               r_aged;

  for (genvar g = 0; g < N; g++) begin : g_ch
    fifo_queue #(
      .DATA_WIDTH (ENTRY_W),
      .DEPTH      (INPUT_QUEUE_SIZE)
    ) u_fifo (
      .clk          (clk_in),
      .rst_n        (reset_n_in),
      .i_push       (request_valid_flatted_in[g] & w_ack[g]),
      .i_push_data  ({request_priority_flatted_in[g*PW +: PW], request_flatted_in[g*W +: W]}),
      .i_pop        (w_pop[g]),
      .o_head_data  (w_head[g]),
      .o_head_valid (w_head_valid[g]),
      .o_not_full   (w_ack[g])
    );

    // A head that has waited AGING_THRESHOLD cycles competes at the top level
    assign w_head_lvl[g]          = w_head[g][ENTRY_W-1 -: PW];
    assign w_aged[g]              = (AGING_THRESHOLD != 0) && (r_age[g] >= AGE_MAX);
    assign w_eff_lvl[g*PW +: PW]  = w_aged[g] ? TOP_LVL : w_head_lvl[g];
  end

  qos_select #(
    .NUM_REQUEST      (N),
    .PRIORITY_WIDTH   (PW),
    .NUM_REQUEST_LOG2 (LW)
  ) u_select (
    .i_valid      (w_head_valid),
    .i_level      (w_eff_lvl),
    .i_aged       (w_aged),
    .i_last_grant (r_last_grant),
    .o_winner     (w_winner),
    .o_any_valid  (w_any)
  );

  assign w_load = !r_valid || issue_ack_in;

  always_comb begin
    w_pop = '0;
    if (w_load && w_any) w_pop[w_winner] = 1'b1;
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int i = 0; i < N; i++) r_age[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!w_head_valid[i] || w_pop[i]) r_age[i] <= '0;
        else if (r_age[i] < AGE_MAX)      r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  // Output stage loads only when empty or being consumed; otherwise holds
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_prio       <= '0;
      r_chan       <= '0;
      r_aged       <= 1'b0;
      r_last_grant <= LW'(N - 1);
    end else if (w_load) begin
      if (w_any) begin
        r_valid      <= 1'b1;
        r_data       <= w_head[w_winner][W-1:0];
        r_prio       <= w_head_lvl[w_winner];
        r_chan       <= w_winner;
        r_aged       <= w_aged[w_winner];
        r_last_grant <= w_winner;
      end else begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_prio  <= '0;
        r_chan  <= '0;
        r_aged  <= 1'b0;
      end
    end
  end

  assign issue_ack_out        = w_ack;
  assign request_out          = r_data;
  assign request_priority_out = r_prio;
  assign request_channel_out  = r_chan;
  assign request_aged_out     = r_aged;
  assign request_valid_out    = r_valid;

endmodule

// File: tb/tb_qos_priority_arbiter.sv
// Directed bench for qos_priority_arbiter with AGING_THRESHOLD=4.
module tb_qos_priority_arbiter;

  localparam int unsigned W  = 64;
  localparam int unsigned N  = 4;
  localparam int unsigned PW = 2;
  localparam int unsigned LW = 2;

  logic           clk_in;
  logic           reset_n_in;
  logic [W*N-1:0] req_data;
  logic [PW*N-1:0] req_prio;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   issue_ack_out;
  logic [W-1:0]   request_out;
  logic [PW-1:0]  request_priority_out;
  logic [LW-1:0]  request_channel_out;
  logic           request_aged_out;
  logic           request_valid_out;
  logic           issue_ack_in;

  int n_tests;
  int n_fail;

  qos_priority_arbiter #(
    .SINGLE_REQUEST_WIDTH_IN_BITS (W),
    .NUM_REQUEST                  (N),
    .INPUT_QUEUE_SIZE             (4),
    .PRIORITY_WIDTH               (PW),
    .AGING_THRESHOLD              (4)
  ) dut (
    .clk_in                      (clk_in),
    .reset_n_in                  (reset_n_in),
    .request_flatted_in          (req_data),
    .request_priority_flatted_in (req_prio),
    .request_valid_flatted_in    (req_valid),
    .issue_ack_out               (issue_ack_out),
    .request_out                 (request_out),
    .request_priority_out        (request_priority_out),
    .request_channel_out         (request_channel_out),
    .request_aged_out            (request_aged_out),
    .request_valid_out           (request_valid_out),
    .issue_ack_in                (issue_ack_in)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic drive(input int ch, input logic [PW-1:0] lvl, input logic [W-1:0] data);
    req_valid[ch]          = 1'b1;
    req_prio[ch*PW +: PW]  = lvl;
    req_data[ch*W +: W]    = data;
  endtask

  task automatic chk_grant(input string tag, input int ch, input int lvl,
                           input logic aged, input logic [63:0] data);
    chk({tag, ".valid"}, 64'(request_valid_out), 64'd1);
    chk({tag, ".chan"},  64'(request_channel_out), 64'(ch));
    chk({tag, ".prio"},  64'(request_priority_out), 64'(lvl));
    chk({tag, ".aged"},  64'(request_aged_out), 64'(aged));
    chk({tag, ".data"},  request_out, data);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset_n_in   = 1'b1;
    issue_ack_in = 1'b0;
    req_valid    = '0;
    req_data     = '0;
    req_prio     = '0;
    #2 reset_n_in = 1'b0;
    repeat (3) @(negedge clk_in);

    // reset state
    chk("rst.valid", 64'(request_valid_out), 64'd0);
    chk("rst.data",  request_out, 64'd0);
    chk("rst.chan",  64'(request_channel_out), 64'd0);
    chk("rst.ack",   64'(issue_ack_out), 64'd0);
    reset_n_in = 1'b1;
    chk("rel.ack_before_edge", 64'(issue_ack_out), 64'd0);
    tick();
    chk("rel.ack_up", 64'(issue_ack_out), 64'hF);

    // 1: four level-0 requests at once, RR from ch0, 2-cycle latency
    issue_ack_in = 1'b1;
    for (int i = 0; i < 4; i++) drive(i, 2'd0, 64'hA0 + 64'(i));
    tick();
    req_valid = '0;
    chk("t1.lat1", 64'(request_valid_out), 64'd0);
    tick();
    chk("t1.lat2", 64'(request_valid_out), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_grant("t1.grant", i, 0, 1'b0, 64'hA0 + 64'(i));
    end
    tick();
    chk("t1.drain.valid", 64'(request_valid_out), 64'd0);
    chk("t1.drain.data",  request_out, 64'd0);

    // 2: higher level wins regardless of RR position
    drive(1, 2'd1, 64'hB1);
    drive(2, 2'd3, 64'hB2);
    tick();
    req_valid = '0;
    tick();
    tick();
    chk_grant("t2.high", 2, 3, 1'b0, 64'hB2);
    tick();
    chk_grant("t2.low", 1, 1, 1'b0, 64'hB1);
    tick();
    chk("t2.drain", 64'(request_valid_out), 64'd0);

    // 3: ch0 starves behind a level-3 stream until aging promotes it
    for (int k = 0; k < 6; k++) begin
      req_valid = '0;
      if (k == 0) drive(0, 2'd0, 64'hC0);
      drive(1, 2'd3, 64'hD0 + 64'(k));
      tick();
      if (k >= 2) chk_grant("t3.stream", 1, 3, 1'b0, 64'hD0 + 64'(k - 2));
    end
    req_valid = '0;
    tick();
    chk_grant("t3.aged", 0, 0, 1'b1, 64'hC0);
    tick();
    chk_grant("t3.resume", 1, 3, 1'b0, 64'hD4);
    tick();
    chk_grant("t3.resume2", 1, 3, 1'b0, 64'hD5);
    tick();
    chk("t3.drain", 64'(request_valid_out), 64'd0);

    // 4: output held under backpressure, FIFO fills and drops its ack
    issue_ack_in = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(2, 2'd1, 64'hE0 + 64'(k));
      tick();
    end
    req_valid = '0;
    chk("t4.full_ack", 64'(issue_ack_out), 64'hB);
    for (int k = 0; k < 5; k++) begin
      chk_grant("t4.hold", 2, 1, 1'b0, 64'hE0);
      tick();
    end
    chk_grant("t4.hold_end", 2, 1, 1'b0, 64'hE0);
    chk("t4.still_full", 64'(issue_ack_out), 64'hB);
    issue_ack_in = 1'b1;
    tick();
    chk_grant("t4.rel_aged", 2, 1, 1'b1, 64'hE1);
    chk("t4.ack_back", 64'(issue_ack_out), 64'hF);
    tick();
    chk_grant("t4.e2", 2, 1, 1'b0, 64'hE2);
    tick();
    chk_grant("t4.e3", 2, 1, 1'b0, 64'hE3);
    tick();
    chk_grant("t4.e4", 2, 1, 1'b0, 64'hE4);
    tick();
    chk("t4.drain", 64'(request_valid_out), 64'd0);

    // 5: single channel granted back-to-back
    for (int k = 0; k < 3; k++) begin
      drive(3, 2'd2, 64'hF0 + 64'(k));
      tick();
      if (k == 2) chk_grant("t5.b2b0", 3, 2, 1'b0, 64'hF0);
    end
    req_valid = '0;
    tick();
    chk_grant("t5.b2b1", 3, 2, 1'b0, 64'hF1);
    tick();
    chk_grant("t5.b2b2", 3, 2, 1'b0, 64'hF2);
    tick();
    chk("t5.drain", 64'(request_valid_out), 64'd0);

    // 6: asynchronous reset mid-burst discards everything
    for (int k = 0; k < 3; k++) begin
      drive(0, 2'd0, 64'h100 + 64'(k));
      drive(1, 2'd0, 64'h200 + 64'(k));
      tick();
    end
    req_valid = '0;
    chk_grant("t6.pre", 0, 0, 1'b0, 64'h100);
    #2 reset_n_in = 1'b0;
    #1;
    chk("t6.async.valid", 64'(request_valid_out), 64'd0);
    chk("t6.async.data",  request_out, 64'd0);
    chk("t6.async.ack",   64'(issue_ack_out), 64'd0);
    @(negedge clk_in);
    reset_n_in = 1'b1;
    tick();
    chk("t6.post.ack",   64'(issue_ack_out), 64'hF);
    chk("t6.post.valid", 64'(request_valid_out), 64'd0);
    tick();
    tick();
    chk("t6.empty.valid", 64'(request_valid_out), 64'd0);
    chk("t6.empty.data",  request_out, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
